// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame receiver.
// Imported by the shift register and the receiver top.
package serial_frame_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_e;

    localparam int unsigned SYNC_W_DEF = 8;
    localparam logic [7:0]  SYNC_DEF   = 8'hA5;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 16;

endpackage

// File: rtl/serial_shift_reg.sv
// Serial-in / parallel-out shift register, new bit enters the LSB.
// Synchronous clear has priority over shifting.
module serial_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         sin_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // Next contents: clear, shift, or hold
    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (en_i) begin
            sr_d = {sr_q[W-2:0], sin_i};
        end
    end

    // Register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync word, then deserializes
// a fixed-length payload; also flags complement violations on d/dn.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned        SYNC_W = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0]  SYNC   = SYNC_DEF,
    parameter int unsigned        DATA_W = DATA_W_DEF,
    parameter int unsigned        CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d,
    input  logic              dn,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              sync_det,
    output logic              comp_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int unsigned FW = $clog2(SYNC_W + 1);
    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e state_q;
    state_e state_d;

    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;
    logic [BW-1:0] bit_q;
    logic [BW-1:0] bit_d;

    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] data_out_d;
    logic              data_valid_q;
    logic              data_valid_d;
    logic              sync_det_q;
    logic              sync_det_d;
    logic              comp_err_q;
    logic              comp_err_d;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [CNT_W-1:0]  frame_cnt_d;

    logic [SYNC_W-1:0] hunt_q;
    logic [DATA_W-1:0] pay_q;
    logic [SYNC_W-1:0] hunt_nxt;
    logic [DATA_W-1:0] pay_nxt;
    logic              in_hunt;
    logic              in_data;
    logic              match;
    logic              last;

    assign in_hunt  = (state_q == HUNT);
    assign in_data  = (state_q == DATA);
    assign hunt_nxt = {hunt_q[SYNC_W-2:0], d};
    assign pay_nxt  = {pay_q[DATA_W-2:0], d};

    // Fill must include the current bit so stale zeros never match
    assign match = in_hunt
                && (fill_q >= FW'(SYNC_W - 1))
                && (hunt_nxt == SYNC);

    assign last = in_data && (bit_q == BW'(DATA_W - 1));

    serial_shift_reg #(
        .W (SYNC_W)
    ) u_hunt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (in_hunt),
        .clr_i (last),
        .sin_i (d),
        .q_o   (hunt_q)
    );

    serial_shift_reg #(
        .W (DATA_W)
    ) u_pay (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (in_data),
        .clr_i (1'b0),
        .sin_i (d),
        .q_o   (pay_q)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT: if (match) state_d = DATA;
            DATA: if (last)  state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Next values for counters, flags and output registers
    always_comb begin
        fill_d       = fill_q;
        bit_d        = bit_q;
        sync_det_d   = match;
        data_valid_d = last;
        data_out_d   = data_out_q;
        frame_cnt_d  = frame_cnt_q;
        comp_err_d   = comp_err_q;

        if (last) begin
            fill_d = '0;
        end else if (in_hunt && (fill_q != FW'(SYNC_W))) begin
            fill_d = fill_q + FW'(1);
        end

        if (match || last) begin
            bit_d = '0;
        end else if (in_data) begin
            bit_d = bit_q + BW'(1);
        end

        if (last) begin
            data_out_d = pay_nxt;
            if (frame_cnt_q != '1) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end

        if (d == dn) begin
            comp_err_d = 1'b1;
        end else if (clr) begin
            comp_err_d = 1'b0;
        end
    end

    // Counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q       <= '0;
            bit_q        <= '0;
            sync_det_q   <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            frame_cnt_q  <= '0;
            comp_err_q   <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            bit_q        <= bit_d;
            sync_det_q   <= sync_det_d;
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
            frame_cnt_q  <= frame_cnt_d;
            comp_err_q   <= comp_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign sync_det   = sync_det_q;
    assign comp_err   = comp_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame receiver: the receiving end of the single-bit stimulus stream the test environment drives into flip-flop-style cells. Samples a serial bit `d` and its complement `dn` on each rising clock edge, hunts for a fixed sync word, deserializes the payload that follows, and reports each frame with a one-cycle valid pulse. Also flags any sampled complement violation (`d == dn`). Sits between the stimulus source / DFF chain and the checking logic of the testbench.

## Interface

Parameters:
- `SYNC_W`, 8: sync word length in bits.
- `SYNC`, 8'hA5: sync word, MSB received first.
- `DATA_W`, 8: payload length in bits.
- `CNT_W`, 16: width of the frame counter.

Ports:
- `clk`  in  1  clock; all sampling on the rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `d`  in  1  serial data bit.
- `dn`  in  1  complement of `d`.
- `clr`  in  1  synchronous clear of `comp_err`.
- `data_out`  out  DATA_W  last received payload, MSB-first assembly.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates.
- `sync_det`  out  1  one-cycle pulse when the sync word is recognised.
- `comp_err`  out  1  sticky complement-violation flag.
- `frame_cnt`  out  CNT_W  completed frames, saturating.

## Operation

- States: HUNT, DATA. Reset state is HUNT.
- HUNT:
  - Each edge shifts `d` into an SYNC_W-bit hunt register: new bit enters the LSB, older bits move toward the MSB.
  - A fill counter counts bits received since entering HUNT, saturating at SYNC_W.
  - Match condition: fill counter, including the current bit, reaches SYNC_W, and the hunt register with the current bit equals `SYNC`.
  - On a match: `sync_det` = 1, bit counter cleared, go to DATA.
  - The fill requirement prevents false detection from stale or cleared register contents, including the case `SYNC == 0`.
- DATA:
  - Each edge shifts `d` into a DATA_W-bit payload shift register, MSB first, and increments the bit counter.
  - On the edge that samples bit DATA_W-1:
    - `data_out` loads the full word (including the current bit).
    - `data_valid` = 1.
    - `frame_cnt` increments unless it is at all-ones.
    - Go to HUNT; the hunt register and fill counter are cleared.
  - Payload bits are never searched for sync, so a payload equal to `SYNC` is still data.
- Complement check:
  - `comp_err` sets on any edge where `d == dn`, in any state.
  - `comp_err` clears on an edge with `clr` = 1.
  - If set and clear occur on the same edge, set wins.
  - A violation does not alter the framing path; `d` is used as the data bit.
- Reset values (asserted asynchronously on `rst_n` low):
  - state = HUNT; all shift registers and counters = 0.
  - `data_out` = 0, `data_valid` = 0, `sync_det` = 0, `comp_err` = 0, `frame_cnt` = 0.
  - Reset mid-frame discards the partial frame: no `data_valid`, no count.

## Timing

- All outputs are registered and change only on rising `clk` or on `rst_n` falling.
- `sync_det` is high for exactly the cycle following the edge that sampled the last sync bit.
- The first payload bit is sampled on the next edge after that.
- Frame length: SYNC_W + DATA_W edges from the first sync bit to `data_valid`.
- `data_valid` is high for exactly one cycle. `data_out` holds its value until the next frame completes.
- Back-to-back frames: the next sync word may begin on the edge immediately after the last payload bit, so a frame can complete every SYNC_W + DATA_W cycles.
- `frame_cnt` and `data_out` update on the same edge as the `data_valid` rise.

## Structure

- Package `serial_frame_pkg` holds:
  - the state enum (HUNT, DATA);
  - default `SYNC_W`, `SYNC`, `DATA_W`, `CNT_W` constants.
- Sub-module `serial_shift_reg`: parameterized width, with inputs for shift-enable, synchronous clear and serial-in, and a parallel output. Instantiated twice, once as the hunt register and once as the payload register.
- The top level contains the FSM, the fill and bit counters, the complement check and the output registers.

## Test plan

- Bits of 8'hA5, then bits of 8'h3C, with `dn` = !`d` throughout:
  - `sync_det` pulses once after bit 8.
  - After bit 16: `data_out` = 8'h3C, `data_valid` high for 1 cycle, `frame_cnt` = 1, `comp_err` = 0.
- Noise bits 1,1,0,1, then 8'hA5, then 8'hFF: exactly one detect, `data_out` = 8'hFF.
- Back-to-back frames A5/12, A5/A5, A5/00 with no gaps:
  - `data_valid` pulses on cycles 16, 32, 48.
  - `data_out` sequence is 12, A5, 00; `frame_cnt` = 3.
  - The A5 payload does not trigger `sync_det`.
- Force `d` = `dn` = 1 for one cycle mid-payload:
  - `comp_err` = 1 and stays set; the frame still completes.
  - Assert `clr` together with another violation: `comp_err` stays 1.
  - Assert `clr` alone: `comp_err` = 0.
- Assert `rst_n` low after the sync word plus 4 payload bits, release, then send A5/5A:
  - The aborted frame produces no `data_valid`.
  - Only one `data_valid` occurs, with `data_out` = 8'h5A and `frame_cnt` = 1.
- With `CNT_W` = 4, send 17 frames: `frame_cnt` saturates at 4'hF.
